// File: rtl/mem_sort_ctrl.sv
// In-place bubble sort controller for a dual-port memory with combinational reads
// and synchronous writes; sorts words 0..highest_add on a start pulse.
module mem_sort_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int SIGNED  = 0,
    parameter int DESCEND = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] highest_add,
    input  logic [DATA_W-1:0] spo,
    input  logic [DATA_W-1:0] dpo,
    output logic [ADDR_W-1:0] add_1,
    output logic [DATA_W-1:0] data_1,
    output logic              we_1,
    output logic [ADDR_W-1:0] radd_2,
    output logic              busy,
    output logic              done,
    output logic [15:0]       swap_cnt,
    output logic [ADDR_W-1:0] pass_cnt
);

    typedef enum logic [2:0] {IDLE, CMP, WR_LO, WR_HI, PASS, DONE} state_t;

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] last, last_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic              swapped, swapped_nxt;
    logic [DATA_W-1:0] a;
    logic [ADDR_W-1:0] add_1_nxt, radd_2_nxt, pass_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              we_nxt, busy_nxt, done_nxt;
    logic [15:0]       swap_nxt;
    logic              end_of_pass;

    // Sign-extend (or zero-extend) one bit so a single signed compare covers both modes.
    function automatic logic out_of_order(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
        logic signed [DATA_W:0] xs, ys;
        xs = {(SIGNED != 0) & x[DATA_W-1], x};
        ys = {(SIGNED != 0) & y[DATA_W-1], y};
        return (DESCEND != 0) ? (xs < ys) : (xs > ys);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    assign end_of_pass = (idx == last - ONE);
    assign busy_nxt    = (state_nxt != IDLE);
    assign done_nxt    = (state_nxt == DONE);

    always_comb begin
        state_nxt   = state;
        last_nxt    = last;
        idx_nxt     = idx;
        swapped_nxt = swapped;
        add_1_nxt   = add_1;
        radd_2_nxt  = radd_2;
        data_nxt    = data_1;
        we_nxt      = 1'b0;
        swap_nxt    = swap_cnt;
        pass_nxt    = pass_cnt;
        // Address outputs are registered, so they are set up on the edge entering CMP.
        case (state)
            IDLE: begin
                if (start) begin
                    last_nxt    = highest_add;
                    swap_nxt    = 16'd0;
                    pass_nxt    = '0;
                    idx_nxt     = '0;
                    swapped_nxt = 1'b0;
                    if (highest_add == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt  = CMP;
                        add_1_nxt  = '0;
                        radd_2_nxt = ONE;
                    end
                end
            end
            CMP: begin
                if (out_of_order(spo, dpo)) begin
                    state_nxt = WR_LO;
                    add_1_nxt = idx;
                    data_nxt  = dpo;
                    we_nxt    = 1'b1;
                end else if (end_of_pass) begin
                    state_nxt = PASS;
                end else begin
                    idx_nxt    = idx + ONE;
                    add_1_nxt  = idx + ONE;
                    radd_2_nxt = idx + TWO;
                end
            end
            WR_LO: begin
                state_nxt = WR_HI;
                add_1_nxt = idx + ONE;
                data_nxt  = a;
                we_nxt    = 1'b1;
            end
            WR_HI: begin
                swapped_nxt = 1'b1;
                swap_nxt    = sat_inc(swap_cnt);
                if (end_of_pass) begin
                    state_nxt = PASS;
                end else begin
                    state_nxt  = CMP;
                    idx_nxt    = idx + ONE;
                    add_1_nxt  = idx + ONE;
                    radd_2_nxt = idx + TWO;
                end
            end
            PASS: begin
                pass_nxt = pass_cnt + ONE;
                if (!swapped || last == ONE) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt   = CMP;
                    last_nxt    = last - ONE;
                    idx_nxt     = '0;
                    swapped_nxt = 1'b0;
                    add_1_nxt   = '0;
                    radd_2_nxt  = ONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= IDLE;
            last     <= '0;
            idx      <= '0;
            swapped  <= 1'b0;
            add_1    <= '0;
            radd_2   <= '0;
            data_1   <= '0;
            we_1     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            swap_cnt <= 16'd0;
            pass_cnt <= '0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            idx      <= idx_nxt;
            swapped  <= swapped_nxt;
            add_1    <= add_1_nxt;
            radd_2   <= radd_2_nxt;
            data_1   <= data_nxt;
            we_1     <= we_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            swap_cnt <= swap_nxt;
            pass_cnt <= pass_nxt;
        end
    end

    // The lower word is held for the second half of a swap.
    always_ff @(posedge sys_clk) begin
        if (state == CMP) a <= spo;
    end

endmodule
